// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, timing constants and the parity helper for
// the UART receiver. Build option: define UARTRX_PARITY_EN to add the
// parity bit (and the PARITY state) to the frame.
package uart_pkg;

   // Clock cycles per serial bit. The receiver's 4-bit counter covers this rate only.
   localparam int         OVERSAMPLE         = 16;
   // Counter value at the middle of the start bit.
   localparam logic [3:0] SAMPLE_MID         = 4'd7;
   // Counter value at the middle of the data, parity and stop bits.
   localparam logic [3:0] SAMPLE_END         = 4'd15;
   // Parity seed: 1 gives odd parity, matching the team transmitter.
   localparam logic       PARITYMODE_DEFAULT = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UARTRX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   // Parity bit the transmitter is expected to send for a data byte.
   function automatic logic exp_parity(input logic seed, input logic [7:0] d);
      return seed ^ (^d);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the asynchronous serial line.
// Both stages reset to 1, which is the idle level of the line.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage resynchronisation of d into the clk domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uartrx.sv
// uartrx: 8-bit UART receiver, 16x oversampled, LSB first, one stop bit.
// Build option: UARTRX_PARITY_EN inserts a parity bit between data and stop
// (expected parity = PARITYMODE ^ XOR(data)); without it perr is tied 0.
// Output handshake: rx_valid is a one-cycle strobe with no back-pressure.
// rx_data, perr and ferr change only in the cycle rx_valid is high, and
// they hold until the next frame completes, so a consumer either takes
// the byte on the strobe or reads the held value later.
// fsm_state exposes the sequencer state for debug and checkers.
module uartrx
   import uart_pkg::*;
#(
   parameter logic PARITYMODE = PARITYMODE_DEFAULT,
   parameter int   OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       perr,
   output logic       ferr,
   output logic       busy,
   output state_t     fsm_state
);

   // Last counter value of a full bit period.
   localparam logic [3:0] BIT_END = 4'(OVERSAMPLE - 1);

   logic       rxs;        // synchronized line
   logic       rx_hist;    // previous synchronized value, for edge detect
   logic [1:0] armed;      // cycles since reset, saturating at 3
   logic       fall;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   logic       pend_ferr;
   logic       done;       // stop bit sampled; outputs load next cycle

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxs)
   );

   // The sync flops and history flop come out of reset at 1, so a line that
   // is already low would look like a falling edge once it reaches rxs.
   // Edges are only believed after three clocks, when rx_hist holds a real
   // sample of the line.
   assign fall = (armed == 2'd3) && rx_hist && !rxs;

`ifdef UARTRX_PARITY_EN
   logic pend_perr;
`else
   logic unused_cfg;
   assign unused_cfg = PARITYMODE;
   assign perr       = 1'b0;
`endif

   // Frame sequencer with its counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_state <= IDLE;
         cnt       <= 4'd0;
         idx       <= 3'd0;
         shift     <= 8'h00;
         pend_ferr <= 1'b0;
         done      <= 1'b0;
         rx_hist   <= 1'b1;
         armed     <= 2'd0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         ferr      <= 1'b0;
         busy      <= 1'b0;
`ifdef UARTRX_PARITY_EN
         pend_perr <= 1'b0;
         perr      <= 1'b0;
`endif
      end else begin
         rx_hist  <= rxs;
         if (armed != 2'd3) begin
            armed <= armed + 2'd1;
         end
         done     <= 1'b0;
         rx_valid <= done;

         // Publish the completed frame; a new start edge detected in this
         // same cycle re-asserts busy below and wins.
         if (done) begin
            rx_data <= shift;
            ferr    <= pend_ferr;
            busy    <= 1'b0;
`ifdef UARTRX_PARITY_EN
            perr    <= pend_perr;
`endif
         end

         case (fsm_state)
            IDLE: begin
               if (fall) begin
                  fsm_state <= START;
                  cnt       <= 4'd0;
                  idx       <= 3'd0;
                  busy      <= 1'b1;
                  pend_ferr <= 1'b0;
`ifdef UARTRX_PARITY_EN
                  pend_perr <= 1'b0;
`endif
               end
            end

            START: begin
               if (cnt == SAMPLE_MID) begin
                  cnt <= 4'd0;
                  if (!rxs) begin
                     fsm_state <= DATA;
                  end else begin
                     // Line went back high before mid-bit: a glitch.
                     fsm_state <= IDLE;
                     busy      <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end

            DATA: begin
               if (cnt == BIT_END) begin
                  cnt        <= 4'd0;
                  shift[idx] <= rxs;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef UARTRX_PARITY_EN
                     fsm_state <= PARITY;
`else
                     fsm_state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end

`ifdef UARTRX_PARITY_EN
            PARITY: begin
               if (cnt == BIT_END) begin
                  cnt       <= 4'd0;
                  pend_perr <= (rxs != exp_parity(PARITYMODE, shift));
                  fsm_state <= STOP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
`endif

            STOP: begin
               if (cnt == BIT_END) begin
                  // Back to IDLE at once so a start edge right after the
                  // stop sample is caught with no idle gap.
                  cnt       <= 4'd0;
                  pend_ferr <= !rxs;
                  done      <= 1'b1;
                  fsm_state <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end

            default: begin
               fsm_state <= IDLE;
               cnt       <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uartrx.sv
// tb_uartrx: self-checking bench for uartrx. Frames are driven bit by bit
// at 16 clocks per bit; a reference model derives each frame's expected
// {perr, ferr, data} and its rx_valid cycle from the frame format alone.
// Follows the UARTRX_PARITY_EN build option of the design.
`timescale 1ns/1ps
module tb_uartrx;
   import uart_pkg::*;

   localparam logic PMODE = 1'b1;
   localparam int   BIT_T = 16;
   localparam int   HALF_BIT = 8;
`ifdef UARTRX_PARITY_EN
   localparam bit   HAS_PAR = 1'b1;
   localparam int   NBITS_AFTER = 10;   // data + parity + stop after the start bit
`else
   localparam bit   HAS_PAR = 1'b0;
   localparam int   NBITS_AFTER = 9;    // data + stop after the start bit
`endif
   // Drive-to-detect: one edge into the first sync flop, one into the
   // second, one for the receiver to act on the edge.
   localparam int   LAT_FIRST = 3;
   // Cycle of the rx_valid strobe relative to the cycle the start bit is driven.
   localparam int   VALID_LAT = LAT_FIRST + HALF_BIT + BIT_T * NBITS_AFTER + 1;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       perr;
   logic       ferr;
   logic       busy;
   state_t     fsm_state;

   always #5 clk = ~clk;

   uartrx #(
      .PARITYMODE (PMODE),
      .OVERSAMPLE (BIT_T)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .perr      (perr),
      .ferr      (ferr),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         busy_cycles = 0;
   logic [9:0] exp_q[$];
   int         exp_t[$];
   logic [9:0] got_q[$];
   int         got_t[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every strobe with its cycle, and count busy-high cycles
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         got_q.push_back({perr, ferr, rx_data});
         got_t.push_back(cyc);
      end
      if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic good_par(input logic [7:0] d);
      return PMODE ^ (^d);
   endfunction

   function automatic logic [9:0] model_frame(input logic [7:0] d, input logic par, input logic stop);
      logic pe;
      pe = HAS_PAR ? (par != good_par(d)) : 1'b0;
      return {pe, ~stop, d};
   endfunction

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      exp_q.push_back(model_frame(d, par, stop));
      exp_t.push_back(cyc + VALID_LAT);
      rxd = 1'b0;
      tick(BIT_T);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(BIT_T);
      end
      if (HAS_PAR) begin
         rxd = par;
         tick(BIT_T);
      end
      rxd = stop;
      tick(BIT_T);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int g0;
      rst = 1'b0;
      rxd = 1'b1;
      tick(4);
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %0h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
      checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr: got %0b expected 0", perr); end
      checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %0b expected 0", ferr); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (fsm_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
      g0 = got_q.size();
      rst = 1'b1;
      tick(20);
      checks++; if (got_q.size() != g0) begin failures++; $display("FAIL reset_idle_valid: got %0d strobes expected 0", got_q.size() - g0); end
   endtask

   task automatic test_good_frame();
      int e0, g0, b0, n;
      e0 = exp_q.size(); g0 = got_q.size(); b0 = busy_cycles;
      send_frame(8'hA5, good_par(8'hA5), 1'b1);
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL good_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL good_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL good_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
      checks++; if (busy_cycles - b0 != VALID_LAT - LAT_FIRST) begin failures++; $display("FAIL good_busy_len: got %0d expected %0d", busy_cycles - b0, VALID_LAT - LAT_FIRST); end
   endtask

   task automatic test_parity_error();
      int e0, g0, n;
      e0 = exp_q.size(); g0 = got_q.size();
      send_frame(8'hA5, 1'b0, 1'b1);
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL parity_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL parity_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL parity_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
   endtask

   task automatic test_framing_error();
      int e0, g0, n;
      e0 = exp_q.size(); g0 = got_q.size();
      send_frame(8'h3C, good_par(8'h3C), 1'b0);
      checks++; if (fsm_state !== IDLE) begin failures++; $display("FAIL ferr_state: got %0d expected %0d", fsm_state, IDLE); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy: got %0b expected 0", busy); end
      rxd = 1'b1;
      tick(4);
      send_frame(8'h55, good_par(8'h55), 1'b1);
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL ferr_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL ferr_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL ferr_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
   endtask

   task automatic test_false_start();
      int g0, b0;
      g0 = got_q.size(); b0 = busy_cycles;
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(40);
      checks++; if (busy_cycles - b0 != HALF_BIT) begin failures++; $display("FAIL glitch_busy_len: got %0d expected %0d", busy_cycles - b0, HALF_BIT); end
      checks++; if (got_q.size() != g0) begin failures++; $display("FAIL glitch_valid: got %0d strobes expected 0", got_q.size() - g0); end
      checks++; if (fsm_state !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected %0d", fsm_state, IDLE); end
   endtask

   task automatic test_back_to_back();
      int e0, g0, n;
      e0 = exp_q.size(); g0 = got_q.size();
      send_frame(8'h00, good_par(8'h00), 1'b1);
      send_frame(8'hFF, good_par(8'hFF), 1'b1);
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL b2b_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL b2b_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL b2b_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
   endtask

   task automatic test_reset_midframe();
      int e0, g0, n;
      logic [7:0] d;
      d = 8'h81;
      g0 = got_q.size();
      rxd = 1'b0;
      tick(BIT_T);
      for (int i = 0; i < 3; i++) begin
         rxd = d[i];
         tick(BIT_T);
      end
      rxd = d[3];
      tick(HALF_BIT);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %0b expected 1", busy); end
      rst = 1'b0;
      #1;
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data: got %0h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid: got %0b expected 0", rx_valid); end
      checks++; if ({perr, ferr} !== 2'b00) begin failures++; $display("FAIL midrst_errs: got %0b expected 00", {perr, ferr}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
      checks++; if (fsm_state !== IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected %0d", fsm_state, IDLE); end
      tick(3);
      rst = 1'b1;
      tick(40);   // line still low: must not be taken as a start edge
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_low_busy: got %0b expected 0", busy); end
      rxd = 1'b1;
      tick(40);
      checks++; if (got_q.size() != g0) begin failures++; $display("FAIL midrst_valid: got %0d strobes expected 0", got_q.size() - g0); end
      e0 = exp_q.size(); g0 = got_q.size();
      send_frame(d, good_par(d), 1'b1);
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL midrst_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL midrst_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL midrst_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
   endtask

   task automatic test_random();
      int e0, g0, n, gap;
      logic [7:0] d;
      logic par, stop;
      e0 = exp_q.size(); g0 = got_q.size();
      for (int k = 0; k < 24; k++) begin
         d    = 8'($urandom_range(0, 255));
         par  = good_par(d);
         if ($urandom_range(0, 7) == 0) par = ~par;
         stop = ($urandom_range(0, 7) != 0);
         send_frame(d, par, stop);
         // A low stop bit needs the line high again before the next start edge.
         gap  = stop ? $urandom_range(0, 3) : $urandom_range(2, 4);
         rxd  = 1'b1;
         tick(gap);
      end
      tick(4);
      n = exp_q.size() - e0;
      checks++; if (got_q.size() - g0 != n) begin failures++; $display("FAIL rand_count: got %0d frames expected %0d", got_q.size() - g0, n); end
      for (int i = 0; i < n && g0 + i < got_q.size(); i++) begin
         checks++; if (got_q[g0+i] !== exp_q[e0+i]) begin failures++; $display("FAIL rand_frame%0d: got {perr,ferr,data}=%03h expected %03h", i, got_q[g0+i], exp_q[e0+i]); end
         checks++; if (got_t[g0+i] != exp_t[e0+i]) begin failures++; $display("FAIL rand_time%0d: got cycle %0d expected %0d", i, got_t[g0+i], exp_t[e0+i]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_framing_error();
      test_false_start();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
